// File: rtl/multicycle_control_fsm_if.sv
// Control interface between the multi-cycle control FSM and the datapath.
// The master side is the FSM: it reads the instruction/ALU status and
// drives every datapath enable and mux select.
interface multicycle_control_fsm_if #(
   parameter int XLEN = 32
);
   logic [6:0]      opcode;
   logic            alu_bcond;
   logic [XLEN-1:0] ecall_reg;
   logic            pc_write;
   logic            ir_write;
   logic            i_or_d;
   logic            mem_read;
   logic            mem_write;
   logic            mem_to_reg;
   logic            pc_to_reg;
   logic            reg_write;
   logic            alu_src_a;
   logic [1:0]      alu_src_b;
   logic [1:0]      alu_op;
   logic            pc_source;
   logic            is_halted;
   logic [3:0]      state;

   modport master (
      input  opcode, alu_bcond, ecall_reg,
      output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
             pc_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             is_halted, state
   );

   modport slave (
      output opcode, alu_bcond, ecall_reg,
      input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
             pc_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             is_halted, state
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM. Steps each instruction through
// IF/ID/EX/MEM/WB, sharing one ALU and one unified memory port, with
// configurable memory wait states and a registered ecall halt flag.
module multicycle_control_fsm #(
   parameter int XLEN     = 32,
   parameter int MEM_WAIT = 0,
   parameter int HALT_VAL = 10
) (
   input logic                      clk,
   input logic                      reset,
   multicycle_control_fsm_if.master bus
);

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_EX_R    = 4'd2,
      S_EX_I    = 4'd3,
      S_EX_LS   = 4'd4,
      S_EX_BR   = 4'd5,
      S_EX_JAL  = 4'd6,
      S_EX_JALR = 4'd7,
      S_MEM_LD  = 4'd8,
      S_MEM_ST  = 4'd9,
      S_WB_ALU  = 4'd10,
      S_WB_LD   = 4'd11,
      S_PC4     = 4'd12,
      S_HALT    = 4'd13
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   state_t     r_state;
   logic [3:0] r_waitCnt;
   logic       r_halted;

   state_t     w_nextState;
   logic [3:0] w_nextWaitCnt;
   logic       w_lastWait;
   logic       w_pcWrite;
   logic       w_irWrite;
   logic       w_iOrD;
   logic       w_memRead;
   logic       w_memWrite;
   logic       w_memToReg;
   logic       w_pcToReg;
   logic       w_regWrite;
   logic       w_aluSrcA;
   logic [1:0] w_aluSrcB;
   logic [1:0] w_aluOp;
   logic       w_pcSource;

   // A memory state finishes once the wait counter has reached MEM_WAIT.
   assign w_lastWait = (r_waitCnt == 4'(MEM_WAIT));

   // State, wait counter and halt flag registers; reset abandons any
   // in-flight instruction and restarts at fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IF;
         r_waitCnt <= 4'd0;
         r_halted  <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_waitCnt <= w_nextWaitCnt;
         r_halted  <= (w_nextState == S_HALT);
      end
   end

   // Next-state decode and Moore outputs; the counter only advances while
   // a memory state is still waiting and is zero everywhere else.
   always_comb begin
      w_nextState   = r_state;
      w_nextWaitCnt = 4'd0;
      w_pcWrite     = 1'b0;
      w_irWrite     = 1'b0;
      w_iOrD        = 1'b0;
      w_memRead     = 1'b0;
      w_memWrite    = 1'b0;
      w_memToReg    = 1'b0;
      w_pcToReg     = 1'b0;
      w_regWrite    = 1'b0;
      w_aluSrcA     = 1'b0;
      w_aluSrcB     = 2'd0;
      w_aluOp       = 2'd0;
      w_pcSource    = 1'b0;
      case (r_state)
         S_IF: begin
            w_memRead = 1'b1;
            w_irWrite = w_lastWait;
            if (w_lastWait) w_nextState = S_ID;
            else            w_nextWaitCnt = r_waitCnt + 4'd1;
         end
         S_ID: begin
            w_aluSrcB = 2'd2;
            case (bus.opcode)
               OP_R:               w_nextState = S_EX_R;
               OP_I:               w_nextState = S_EX_I;
               OP_LOAD, OP_STORE:  w_nextState = S_EX_LS;
               OP_BRANCH:          w_nextState = S_EX_BR;
               OP_JAL:             w_nextState = S_EX_JAL;
               OP_JALR:            w_nextState = S_EX_JALR;
               OP_SYSTEM:          w_nextState = (bus.ecall_reg == XLEN'(HALT_VAL)) ? S_HALT : S_PC4;
               default:            w_nextState = S_PC4;
            endcase
         end
         S_EX_R: begin
            w_aluSrcA   = 1'b1;
            w_aluOp     = 2'd2;
            w_nextState = S_WB_ALU;
         end
         S_EX_I: begin
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = 2'd2;
            w_aluOp     = 2'd2;
            w_nextState = S_WB_ALU;
         end
         S_EX_LS: begin
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = 2'd2;
            w_nextState = (bus.opcode == OP_STORE) ? S_MEM_ST : S_MEM_LD;
         end
         S_EX_BR: begin
            w_aluSrcA = 1'b1;
            w_aluOp   = 2'd1;
            if (bus.alu_bcond) begin
               w_pcWrite   = 1'b1;
               w_pcSource  = 1'b1;
               w_nextState = S_IF;
            end else begin
               w_nextState = S_PC4;
            end
         end
         S_EX_JAL: begin
            w_regWrite  = 1'b1;
            w_pcToReg   = 1'b1;
            w_pcWrite   = 1'b1;
            w_pcSource  = 1'b1;
            w_nextState = S_IF;
         end
         S_EX_JALR: begin
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = 2'd2;
            w_pcWrite   = 1'b1;
            w_regWrite  = 1'b1;
            w_pcToReg   = 1'b1;
            w_nextState = S_IF;
         end
         S_MEM_LD: begin
            w_iOrD    = 1'b1;
            w_memRead = 1'b1;
            if (w_lastWait) w_nextState = S_WB_LD;
            else            w_nextWaitCnt = r_waitCnt + 4'd1;
         end
         S_MEM_ST: begin
            w_iOrD = 1'b1;
            if (w_lastWait) begin
               w_memWrite  = 1'b1;
               w_aluSrcB   = 2'd1;
               w_pcWrite   = 1'b1;
               w_nextState = S_IF;
            end else begin
               w_nextWaitCnt = r_waitCnt + 4'd1;
            end
         end
         S_WB_ALU: begin
            w_regWrite  = 1'b1;
            w_aluSrcB   = 2'd1;
            w_pcWrite   = 1'b1;
            w_nextState = S_IF;
         end
         S_WB_LD: begin
            w_regWrite  = 1'b1;
            w_memToReg  = 1'b1;
            w_aluSrcB   = 2'd1;
            w_pcWrite   = 1'b1;
            w_nextState = S_IF;
         end
         S_PC4: begin
            w_aluSrcB   = 2'd1;
            w_pcWrite   = 1'b1;
            w_nextState = S_IF;
         end
         S_HALT: begin
            w_nextState = S_HALT;
         end
         default: begin
            w_nextState = S_IF;
         end
      endcase
   end

   // Write enables are suppressed while reset is held so an abandoned
   // instruction can never commit anything.
   assign bus.pc_write   = w_pcWrite  & ~reset;
   assign bus.ir_write   = w_irWrite  & ~reset;
   assign bus.mem_write  = w_memWrite & ~reset;
   assign bus.reg_write  = w_regWrite & ~reset;
   assign bus.i_or_d     = w_iOrD;
   assign bus.mem_read   = w_memRead;
   assign bus.mem_to_reg = w_memToReg;
   assign bus.pc_to_reg  = w_pcToReg;
   assign bus.alu_src_a  = w_aluSrcA;
   assign bus.alu_src_b  = w_aluSrcB;
   assign bus.alu_op     = w_aluOp;
   assign bus.pc_source  = w_pcSource;
   assign bus.is_halted  = r_halted;
   assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: three instances with
// MEM_WAIT of 0, 2 and 3; a queue of per-cycle expected state/outputs.
module tb_multicycle_control_fsm;

   localparam int S_IF = 0, S_ID = 1, S_EX_R = 2, S_EX_I = 3, S_EX_LS = 4,
                  S_EX_BR = 5, S_EX_JAL = 6, S_EX_JALR = 7, S_MEM_LD = 8,
                  S_MEM_ST = 9, S_WB_ALU = 10, S_WB_LD = 11, S_PC4 = 12,
                  S_HALT = 13;

   // ctrl bit order: pc_write ir_write i_or_d mem_read mem_write mem_to_reg
   // pc_to_reg reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_source is_halted
   localparam logic [14:0] WE_MASK = 15'b110_0100_1000_0000;

   typedef struct packed {
      logic [3:0]  st;
      logic [14:0] ctrl;
   } exp_t;

   logic clk;
   logic rst0, rst2, rst3;
   int   nChecks = 0;
   int   nFail   = 0;
   exp_t sb[$];

   multicycle_control_fsm_if #(.XLEN(32)) bus0();
   multicycle_control_fsm_if #(.XLEN(32)) bus2();
   multicycle_control_fsm_if #(.XLEN(32)) bus3();

   multicycle_control_fsm #(.XLEN(32), .MEM_WAIT(0), .HALT_VAL(10)) u0 (.clk(clk), .reset(rst0), .bus(bus0));
   multicycle_control_fsm #(.XLEN(32), .MEM_WAIT(2), .HALT_VAL(10)) u2 (.clk(clk), .reset(rst2), .bus(bus2));
   multicycle_control_fsm #(.XLEN(32), .MEM_WAIT(3), .HALT_VAL(10)) u3 (.clk(clk), .reset(rst3), .bus(bus3));

   logic [14:0] act0, act2, act3;
   assign act0 = {bus0.pc_write, bus0.ir_write, bus0.i_or_d, bus0.mem_read, bus0.mem_write,
                  bus0.mem_to_reg, bus0.pc_to_reg, bus0.reg_write, bus0.alu_src_a,
                  bus0.alu_src_b, bus0.alu_op, bus0.pc_source, bus0.is_halted};
   assign act2 = {bus2.pc_write, bus2.ir_write, bus2.i_or_d, bus2.mem_read, bus2.mem_write,
                  bus2.mem_to_reg, bus2.pc_to_reg, bus2.reg_write, bus2.alu_src_a,
                  bus2.alu_src_b, bus2.alu_op, bus2.pc_source, bus2.is_halted};
   assign act3 = {bus3.pc_write, bus3.ir_write, bus3.i_or_d, bus3.mem_read, bus3.mem_write,
                  bus3.mem_to_reg, bus3.pc_to_reg, bus3.reg_write, bus3.alu_src_a,
                  bus3.alu_src_b, bus3.alu_op, bus3.pc_source, bus3.is_halted};

   // Free-running 10 ns clock shared by all instances.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for one cycle of a state, written from the state table.
   function automatic logic [14:0] expCtrl(input int s, input bit last, input bit bcond);
      logic [14:0] c;
      logic [14:0] pc4;
      c   = '0;
      pc4 = 15'b100_0000_0001_0000;
      case (s)
         S_IF:      begin c[11] = 1'b1; c[13] = last; end
         S_ID:      c[5:4] = 2'd2;
         S_EX_R:    begin c[6] = 1'b1; c[3:2] = 2'd2; end
         S_EX_I:    begin c[6] = 1'b1; c[5:4] = 2'd2; c[3:2] = 2'd2; end
         S_EX_LS:   begin c[6] = 1'b1; c[5:4] = 2'd2; end
         S_EX_BR:   begin c[6] = 1'b1; c[3:2] = 2'd1; if (bcond) begin c[14] = 1'b1; c[1] = 1'b1; end end
         S_EX_JAL:  begin c[7] = 1'b1; c[8] = 1'b1; c[14] = 1'b1; c[1] = 1'b1; end
         S_EX_JALR: begin c[6] = 1'b1; c[5:4] = 2'd2; c[14] = 1'b1; c[7] = 1'b1; c[8] = 1'b1; end
         S_MEM_LD:  begin c[12] = 1'b1; c[11] = 1'b1; end
         S_MEM_ST:  begin c[12] = 1'b1; if (last) begin c = c | pc4; c[10] = 1'b1; end end
         S_WB_ALU:  begin c = pc4; c[7] = 1'b1; end
         S_WB_LD:   begin c = pc4; c[7] = 1'b1; c[9] = 1'b1; end
         S_PC4:     c = pc4;
         S_HALT:    c[0] = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

   // Push a single-cycle state onto the scoreboard.
   task automatic pushState(input int s, input bit bcond);
      exp_t e;
      e.st   = 4'(s);
      e.ctrl = expCtrl(s, 1'b1, bcond);
      sb.push_back(e);
   endtask

   // Push a memory state lasting w+1 cycles, the final one flagged as last.
   task automatic pushMem(input int s, input int w);
      exp_t e;
      for (int k = 0; k <= w; k++) begin
         e.st   = 4'(s);
         e.ctrl = expCtrl(s, (k == w), 1'b0);
         sb.push_back(e);
      end
   endtask

   // Reset all instances, check the held-reset outputs, then release.
   task automatic test_reset;
      exp_t e;
      @(negedge clk);
      rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      e.st   = 4'(S_IF);
      e.ctrl = expCtrl(S_IF, 1'b1, 1'b0) & ~WE_MASK;
      nChecks++;
      if (bus0.state !== e.st || act0 !== e.ctrl) begin
         nFail++;
         $display("[TB] FAIL reset_w0: state=%0d ctrl=%b expected state=%0d ctrl=%b", bus0.state, act0, e.st, e.ctrl);
      end
      e.ctrl = expCtrl(S_IF, 1'b0, 1'b0) & ~WE_MASK;
      nChecks++;
      if (bus2.state !== e.st || act2 !== e.ctrl) begin
         nFail++;
         $display("[TB] FAIL reset_w2: state=%0d ctrl=%b expected state=%0d ctrl=%b", bus2.state, act2, e.st, e.ctrl);
      end
      @(negedge clk);
      rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
      #1;
   endtask

   // add on the zero-wait instance: IF, ID, EX_R, WB_ALU.
   task automatic test_add;
      exp_t e;
      int   cyc = 0;
      bus0.opcode = 7'b0110011;
      pushMem(S_IF, 0); pushState(S_ID, 0); pushState(S_EX_R, 0); pushState(S_WB_ALU, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         nChecks++;
         if (bus0.state !== e.st || act0 !== e.ctrl) begin
            nFail++;
            $display("[TB] FAIL add cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus0.state, act0, e.st, e.ctrl);
         end
         @(posedge clk); #1;
      end
   endtask

   // beq taken (3 cycles) then not taken (EX_BR then PC4, 4 cycles).
   task automatic test_branch;
      exp_t e;
      int   cyc = 0;
      bus0.opcode = 7'b1100011;
      for (int t = 0; t < 2; t++) begin
         bus0.alu_bcond = (t == 0);
         pushMem(S_IF, 0); pushState(S_ID, 0); pushState(S_EX_BR, (t == 0));
         if (t != 0) pushState(S_PC4, 0);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            nChecks++;
            if (bus0.state !== e.st || act0 !== e.ctrl) begin
               nFail++;
               $display("[TB] FAIL branch cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus0.state, act0, e.st, e.ctrl);
            end
            @(posedge clk); #1;
         end
      end
      bus0.alu_bcond = 1'b0;
   endtask

   // jal and jalr each finish in their execute state.
   task automatic test_jumps;
      exp_t e;
      int   cyc = 0;
      for (int t = 0; t < 2; t++) begin
         bus0.opcode = (t == 0) ? 7'b1101111 : 7'b1100111;
         pushMem(S_IF, 0); pushState(S_ID, 0); pushState((t == 0) ? S_EX_JAL : S_EX_JALR, 0);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            cyc++;
            nChecks++;
            if (bus0.state !== e.st || act0 !== e.ctrl) begin
               nFail++;
               $display("[TB] FAIL jump cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus0.state, act0, e.st, e.ctrl);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   // sw immediately followed by an unknown opcode treated as a nop.
   task automatic test_back_to_back;
      exp_t e;
      int   cyc = 0;
      int   memWrites = 0;
      int   pcWrites = 0;
      bus0.opcode = 7'b0100011;
      pushMem(S_IF, 0); pushState(S_ID, 0); pushState(S_EX_LS, 0); pushMem(S_MEM_ST, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         nChecks++;
         if (bus0.state !== e.st || act0 !== e.ctrl) begin
            nFail++;
            $display("[TB] FAIL store cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus0.state, act0, e.st, e.ctrl);
         end
         memWrites += int'(bus0.mem_write);
         @(posedge clk); #1;
      end
      nChecks++;
      if (memWrites !== 1) begin
         nFail++;
         $display("[TB] FAIL store_memwrite_count: got %0d expected 1", memWrites);
      end
      bus0.opcode = 7'b0000000;
      pushMem(S_IF, 0); pushState(S_ID, 0); pushState(S_PC4, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         nChecks++;
         if (bus0.state !== e.st || act0 !== e.ctrl) begin
            nFail++;
            $display("[TB] FAIL nop cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus0.state, act0, e.st, e.ctrl);
         end
         pcWrites += int'(bus0.pc_write);
         @(posedge clk); #1;
      end
      nChecks++;
      if (pcWrites !== 1) begin
         nFail++;
         $display("[TB] FAIL nop_pcwrite_count: got %0d expected 1", pcWrites);
      end
   endtask

   // ecall with x17=9 is a nop; with x17=10 it halts for good.
   task automatic test_ecall;
      exp_t e;
      int   cyc = 0;
      bus0.opcode    = 7'b1110011;
      bus0.ecall_reg = 32'd9;
      pushMem(S_IF, 0); pushState(S_ID, 0); pushState(S_PC4, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         nChecks++;
         if (bus0.state !== e.st || act0 !== e.ctrl) begin
            nFail++;
            $display("[TB] FAIL ecall_nohalt cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus0.state, act0, e.st, e.ctrl);
         end
         @(posedge clk); #1;
      end
      bus0.ecall_reg = 32'd10;
      pushMem(S_IF, 0); pushState(S_ID, 0);
      for (int k = 0; k < 20; k++) pushState(S_HALT, 0);
      cyc = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         nChecks++;
         if (bus0.state !== e.st || act0 !== e.ctrl) begin
            nFail++;
            $display("[TB] FAIL ecall_halt cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus0.state, act0, e.st, e.ctrl);
         end
         @(posedge clk); #1;
      end
   endtask

   // lw with two wait states: 9 cycles, one ir_write pulse on IF cycle 3.
   task automatic test_load_wait;
      exp_t e;
      int   cyc = 0;
      int   irPulses = 0;
      @(negedge clk); rst2 = 1'b1;
      @(posedge clk);
      @(negedge clk); rst2 = 1'b0; #1;
      bus2.opcode = 7'b0000011;
      pushMem(S_IF, 2); pushState(S_ID, 0); pushState(S_EX_LS, 0); pushMem(S_MEM_LD, 2); pushState(S_WB_LD, 0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         nChecks++;
         if (bus2.state !== e.st || act2 !== e.ctrl) begin
            nFail++;
            $display("[TB] FAIL load cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus2.state, act2, e.st, e.ctrl);
         end
         irPulses += int'(bus2.ir_write);
         @(posedge clk); #1;
      end
      nChecks++;
      if (irPulses !== 1) begin
         nFail++;
         $display("[TB] FAIL load_irwrite_count: got %0d expected 1", irPulses);
      end
      nChecks++;
      if (bus2.state !== 4'(S_IF)) begin
         nFail++;
         $display("[TB] FAIL load_after: state=%0d expected %0d", bus2.state, S_IF);
      end
   endtask

   // Reset arriving in MEM_ST wait cycle 1 (MEM_WAIT=3) abandons the store.
   task automatic test_reset_mid_store;
      exp_t e;
      int   cyc = 0;
      @(negedge clk); rst3 = 1'b1;
      @(posedge clk);
      @(negedge clk); rst3 = 1'b0; #1;
      bus3.opcode = 7'b0100011;
      pushMem(S_IF, 3); pushState(S_ID, 0); pushState(S_EX_LS, 0);
      e.st = 4'(S_MEM_ST); e.ctrl = expCtrl(S_MEM_ST, 1'b0, 1'b0); sb.push_back(e);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         nChecks++;
         if (bus3.state !== e.st || act3 !== e.ctrl) begin
            nFail++;
            $display("[TB] FAIL midstore cyc%0d: state=%0d ctrl=%b expected state=%0d ctrl=%b", cyc, bus3.state, act3, e.st, e.ctrl);
         end
         @(posedge clk); #1;
      end
      nChecks++;
      if (bus3.state !== 4'(S_MEM_ST) || act3 !== expCtrl(S_MEM_ST, 1'b0, 1'b0)) begin
         nFail++;
         $display("[TB] FAIL midstore_wait1: state=%0d ctrl=%b expected state=%0d", bus3.state, act3, S_MEM_ST);
      end
      rst3 = 1'b1;
      #1;
      nChecks++;
      if (bus3.mem_write !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL midstore_memwrite_in_reset: got %b expected 0", bus3.mem_write);
      end
      @(posedge clk); #1;
      nChecks++;
      if (bus3.state !== 4'(S_IF) || bus3.mem_write !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL midstore_after_reset: state=%0d mem_write=%b expected state=%0d mem_write=0", bus3.state, bus3.mem_write, S_IF);
      end
      @(negedge clk); rst3 = 1'b0;
   endtask

   // Bound on total run time in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence.
   initial begin
      rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
      bus0.opcode = 7'd0; bus0.alu_bcond = 1'b0; bus0.ecall_reg = 32'd0;
      bus2.opcode = 7'd0; bus2.alu_bcond = 1'b0; bus2.ecall_reg = 32'd0;
      bus3.opcode = 7'd0; bus3.alu_bcond = 1'b0; bus3.ecall_reg = 32'd0;
      test_reset();
      test_add();
      test_branch();
      test_jumps();
      test_back_to_back();
      test_ecall();
      test_load_wait();
      test_reset_mid_store();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
